// File: rtl/tank_pkg.sv
// Shared types and constants for the tank movement and bullet blocks.
package tank_pkg;

   typedef enum logic [1:0] {UP = 2'd0, RIGHT = 2'd1, DOWN = 2'd2, LEFT = 2'd3} dir_t;
   typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, CHECK = 2'd2} mover_state_t;

   localparam logic [7:0] KEY_W     = 8'h1A;
   localparam logic [7:0] KEY_A     = 8'h04;
   localparam logic [7:0] KEY_S     = 8'h16;
   localparam logic [7:0] KEY_D     = 8'h07;
   localparam logic [7:0] KEY_UP    = 8'h52;
   localparam logic [7:0] KEY_DOWN  = 8'h51;
   localparam logic [7:0] KEY_LEFT  = 8'h50;
   localparam logic [7:0] KEY_RIGHT = 8'h4F;

   localparam logic [1:0] TILE_PASSABLE = 2'd0;

endpackage

// File: rtl/tank_key_decode.sv
// Maps a USB keycode to a direction for one player's keymap (0 = WASD, 1 = arrows).
module tank_key_decode
   import tank_pkg::*;
#(
   parameter int PLAYER = 0
) (
   input  logic [7:0] keycode_i,
   output dir_t       dir_o,
   output logic       valid_o
);

   always_comb begin
      dir_o   = UP;
      valid_o = 1'b0;
      if (PLAYER == 0) begin
         case (keycode_i)
            KEY_W:   begin dir_o = UP;    valid_o = 1'b1; end
            KEY_D:   begin dir_o = RIGHT; valid_o = 1'b1; end
            KEY_S:   begin dir_o = DOWN;  valid_o = 1'b1; end
            KEY_A:   begin dir_o = LEFT;  valid_o = 1'b1; end
            default: ;
         endcase
      end else begin
         case (keycode_i)
            KEY_UP:    begin dir_o = UP;    valid_o = 1'b1; end
            KEY_RIGHT: begin dir_o = RIGHT; valid_o = 1'b1; end
            KEY_DOWN:  begin dir_o = DOWN;  valid_o = 1'b1; end
            KEY_LEFT:  begin dir_o = LEFT;  valid_o = 1'b1; end
            default:   ;
         endcase
      end
   end

endmodule

// File: rtl/tank_grid_mover.sv
// Moves one tank a tile per accepted step, checking the shared tile map through
// a one-cycle synchronous read port before committing.
module tank_grid_mover
   import tank_pkg::*;
#(
   parameter int PLAYER      = 0,
   parameter int TILE_BITS   = 5,
   parameter int GRID_W      = 20,
   parameter int GRID_H      = 15,
   parameter int PIX_W       = 10,
   parameter int MOVE_PERIOD = 5,
   parameter int TURN_FIRST  = 1,
   parameter int START_COL   = (PLAYER == 0) ? 1 : 18,
   parameter int START_ROW   = (PLAYER == 0) ? 13 : 1,
   parameter int ADDR_W      = 9
) (
   input  logic              frame_clk,
   input  logic              Reset,
   input  logic [7:0]        keycode,
   input  logic              respawn,
   output logic              map_rd_en,
   output logic [ADDR_W-1:0] map_addr,
   input  logic [1:0]        map_data,
   output logic [PIX_W-1:0]  TankX,
   output logic [PIX_W-1:0]  TankY,
   output dir_t              facing,
   output logic              moved,
   output logic              blocked
);

   localparam int COL_W = $clog2(GRID_W);
   localparam int ROW_W = $clog2(GRID_H);
   localparam int CD_W  = $clog2(MOVE_PERIOD + 1);
   localparam logic [COL_W-1:0] COL0  = COL_W'(START_COL);
   localparam logic [ROW_W-1:0] ROW0  = ROW_W'(START_ROW);
   localparam logic [COL_W-1:0] COL_MAX = COL_W'(GRID_W - 1);
   localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(GRID_H - 1);
   localparam logic [CD_W-1:0]  CD_LOAD = CD_W'(MOVE_PERIOD);
   localparam dir_t             DIR0  = (PLAYER == 0) ? UP : DOWN;

   mover_state_t      state_q, state_d;
   logic [COL_W-1:0]  col_q, col_d, tcol_q, tcol_d;
   logic [ROW_W-1:0]  row_q, row_d, trow_q, trow_d;
   dir_t              facing_q, facing_d;
   logic [CD_W-1:0]   cd_q, cd_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              rd_q, rd_d, moved_q, moved_d, blk_q, blk_d;

   dir_t              key_dir;
   logic              key_vld;
   logic              at_edge;
   logic [COL_W-1:0]  ncol;
   logic [ROW_W-1:0]  nrow;

   tank_key_decode #(.PLAYER(PLAYER)) u_dec (
      .keycode_i (keycode),
      .dir_o     (key_dir),
      .valid_o   (key_vld)
   );

   always_comb begin
      state_d  = state_q;
      col_d    = col_q;
      row_d    = row_q;
      tcol_d   = tcol_q;
      trow_d   = trow_q;
      facing_d = facing_q;
      cd_d     = cd_q;
      addr_d   = addr_q;
      rd_d     = 1'b0;
      moved_d  = 1'b0;
      blk_d    = 1'b0;
      at_edge  = 1'b0;
      ncol     = col_q;
      nrow     = row_q;

      case (state_q)
         IDLE: begin
            if (cd_q != '0) begin
               cd_d = cd_q - 1'b1;
            end else if (key_vld) begin
               if ((TURN_FIRST != 0) && (key_dir != facing_q)) begin
                  facing_d = key_dir;
                  cd_d     = CD_LOAD;
               end else begin
                  facing_d = key_dir;
                  // Edge test happens before the +/-1 so the unsigned math never wraps.
                  case (key_dir)
                     UP:      begin at_edge = (row_q == '0);     nrow = row_q - 1'b1; end
                     DOWN:    begin at_edge = (row_q == ROW_MAX); nrow = row_q + 1'b1; end
                     LEFT:    begin at_edge = (col_q == '0);     ncol = col_q - 1'b1; end
                     default: begin at_edge = (col_q == COL_MAX); ncol = col_q + 1'b1; end
                  endcase
                  if (at_edge) begin
                     blk_d = 1'b1;
                     cd_d  = CD_LOAD;
                  end else begin
                     tcol_d  = ncol;
                     trow_d  = nrow;
                     addr_d  = ADDR_W'(nrow) * ADDR_W'(GRID_W) + ADDR_W'(ncol);
                     rd_d    = 1'b1;
                     state_d = REQ;
                  end
               end
            end
         end
         REQ: state_d = CHECK;
         CHECK: begin
            if (map_data == TILE_PASSABLE) begin
               col_d   = tcol_q;
               row_d   = trow_q;
               moved_d = 1'b1;
            end else begin
               blk_d = 1'b1;
            end
            cd_d    = CD_LOAD;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (respawn) begin
         state_d  = IDLE;
         col_d    = COL0;
         row_d    = ROW0;
         facing_d = DIR0;
         cd_d     = '0;
         rd_d     = 1'b0;
         moved_d  = 1'b0;
         blk_d    = 1'b0;
      end
   end

   always_ff @(posedge frame_clk or negedge Reset) begin
      if (!Reset) begin
         state_q  <= IDLE;
         col_q    <= COL0;
         row_q    <= ROW0;
         tcol_q   <= COL0;
         trow_q   <= ROW0;
         facing_q <= DIR0;
         cd_q     <= '0;
         addr_q   <= '0;
         rd_q     <= 1'b0;
         moved_q  <= 1'b0;
         blk_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         col_q    <= col_d;
         row_q    <= row_d;
         tcol_q   <= tcol_d;
         trow_q   <= trow_d;
         facing_q <= facing_d;
         cd_q     <= cd_d;
         addr_q   <= addr_d;
         rd_q     <= rd_d;
         moved_q  <= moved_d;
         blk_q    <= blk_d;
      end
   end

   assign map_rd_en = rd_q;
   assign map_addr  = addr_q;
   assign TankX     = PIX_W'(col_q) << TILE_BITS;
   assign TankY     = PIX_W'(row_q) << TILE_BITS;
   assign facing    = facing_q;
   assign moved     = moved_q;
   assign blocked   = blk_q;

endmodule

// File: tb/tb_tank_grid_mover.sv
// Scoreboard bench: one mover per keymap, each backed by a synchronous tile RAM.
module tb_tank_grid_mover;
   import tank_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst0_n, rst1_n, rsp0, rsp1;
   logic [7:0] key0, key1;
   logic       rd0, rd1, mv0, mv1, bl0, bl1;
   logic [8:0] addr0, addr1;
   logic [1:0] md0, md1, f0, f1;
   logic [9:0] x0, y0, x1, y1;
   logic [1:0] mem0 [300];
   logic [1:0] mem1 [300];

   typedef struct {int kind; int addr; int x; int y; int fac; int gap;} ev_t;
   ev_t q0[$];
   ev_t q1[$];
   int errors = 0, checks = 0, cyc = 0, last0 = 0, last1 = 0;

   tank_grid_mover #(.PLAYER(0)) u0 (
      .frame_clk(clk), .Reset(rst0_n), .keycode(key0), .respawn(rsp0),
      .map_rd_en(rd0), .map_addr(addr0), .map_data(md0),
      .TankX(x0), .TankY(y0), .facing(f0), .moved(mv0), .blocked(bl0));

   tank_grid_mover #(.PLAYER(1)) u1 (
      .frame_clk(clk), .Reset(rst1_n), .keycode(key1), .respawn(rsp1),
      .map_rd_en(rd1), .map_addr(addr1), .map_data(md1),
      .TankX(x1), .TankY(y1), .facing(f1), .moved(mv1), .blocked(bl1));

   always @(posedge clk) begin
      cyc++;
      if (rd0) md0 <= mem0[addr0];
      if (rd1) md1 <= mem1[addr1];
   end

   // kind: 0 = map read, 1 = moved, 2 = blocked, 3 = more than one at once
   function automatic int kind_of(logic rd, logic mv, logic bl);
      if (int'(rd) + int'(mv) + int'(bl) > 1) return 3;
      if (rd) return 0;
      if (mv) return 1;
      return 2;
   endfunction

   task automatic cmp_ev(string who, ev_t e, int k, int a, int x, int y, int f, int g);
      checks++;
      if (e.kind != k || (k == 0 && e.addr != a) ||
          (k != 0 && (e.x != x || e.y != y || e.fac != f)) || (e.gap != 0 && e.gap != g)) begin
         errors++;
         $display("FAIL %s_event: got kind=%0d addr=%0d x=%0d y=%0d facing=%0d gap=%0d; want kind=%0d addr=%0d x=%0d y=%0d facing=%0d gap=%0d",
                  who, k, a, x, y, f, g, e.kind, e.addr, e.x, e.y, e.fac, e.gap);
      end
   endtask

   always @(negedge clk) begin
      if (rst0_n && (rd0 || mv0 || bl0)) begin
         if (q0.size() == 0) begin
            checks++; errors++;
            $display("FAIL u0_unexpected: got kind=%0d x=%0d y=%0d, want no event", kind_of(rd0, mv0, bl0), x0, y0);
         end else cmp_ev("u0", q0.pop_front(), kind_of(rd0, mv0, bl0), addr0, x0, y0, f0, cyc - last0);
         last0 = cyc;
      end
      if (rst1_n && (rd1 || mv1 || bl1)) begin
         if (q1.size() == 0) begin
            checks++; errors++;
            $display("FAIL u1_unexpected: got kind=%0d x=%0d y=%0d, want no event", kind_of(rd1, mv1, bl1), x1, y1);
         end else cmp_ev("u1", q1.pop_front(), kind_of(rd1, mv1, bl1), addr1, x1, y1, f1, cyc - last1);
         last1 = cyc;
      end
   end

   function automatic void exp0(int k, int a, int x, int y, int f, int g);
      ev_t e = '{k, a, x, y, f, g};
      q0.push_back(e);
   endfunction

   function automatic void exp1(int k, int a, int x, int y, int f, int g);
      ev_t e = '{k, a, x, y, f, g};
      q1.push_back(e);
   endfunction

   task automatic chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   task automatic tick(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      key0 = 8'h00; key1 = 8'h00; rsp0 = 1'b0; rsp1 = 1'b0;
      rst0_n = 1'b0; rst1_n = 1'b0; md0 = 2'd0; md1 = 2'd0;
      for (int i = 0; i < 300; i++) begin mem0[i] = 2'd0; mem1[i] = 2'd0; end
      #12;
      chk("rst_x0", x0, 32);   chk("rst_y0", y0, 416);
      chk("rst_f0", f0, 0);    chk("rst_rd0", rd0, 0);
      chk("rst_x1", x1, 576);  chk("rst_y1", y1, 32);
      chk("rst_f1", f1, 2);    chk("rst_addr0", addr0, 0);
      rst0_n = 1'b1; rst1_n = 1'b1;
      tick(1);

      // turn only, then step right onto open tile 262
      key0 = KEY_D; tick(1); key0 = 8'h00;
      chk("turn_f0", f0, 1); chk("turn_x0", x0, 32);
      tick(5);
      exp0(0, 262, 0, 0, 0, 0);
      exp0(1, 0, 64, 416, 1, 2);
      key0 = KEY_D; tick(1); key0 = 8'h00; tick(3);
      chk("step_x0", x0, 64);

      rsp0 = 1'b1; tick(1); rsp0 = 1'b0;
      chk("rsp_x0", x0, 32); chk("rsp_f0", f0, 0);

      // wall at 262: held D retries every 8 frames
      mem0[262] = 2'd1;
      exp0(0, 262, 0, 0, 0, 0);
      exp0(2, 0, 32, 416, 1, 2);
      exp0(0, 262, 0, 0, 0, 6);
      exp0(2, 0, 32, 416, 1, 2);
      exp0(0, 262, 0, 0, 0, 6);
      exp0(2, 0, 32, 416, 1, 2);
      key0 = KEY_D; tick(25); key0 = 8'h00; tick(8);
      chk("wall_x0", x0, 32);

      // held W up an open column: 5 steps in 40 frames
      rsp0 = 1'b1; tick(1); rsp0 = 1'b0;
      for (int i = 0; i < 5; i++) begin
         exp0(0, (12 - i) * 20 + 1, 0, 0, 0, (i == 0) ? 0 : 6);
         exp0(1, 0, 32, (12 - i) * 32, 0, 2);
      end
      key0 = KEY_W; tick(40); key0 = 8'h00; tick(8);
      chk("hold_y0", y0, 256);

      // respawn during REQ drops the read; next key honoured at once
      exp0(0, 141, 0, 0, 0, 0);
      key0 = KEY_W; tick(1); key0 = 8'h00; rsp0 = 1'b1; tick(1); rsp0 = 1'b0;
      chk("rspreq_rd0", rd0, 0); chk("rspreq_x0", x0, 32);
      chk("rspreq_y0", y0, 416); chk("rspreq_f0", f0, 0);
      exp0(0, 241, 0, 0, 0, 2);
      exp0(1, 0, 32, 384, 0, 2);
      key0 = KEY_W; tick(1); key0 = 8'h00; tick(8);

      // async reset while in CHECK
      exp0(0, 221, 0, 0, 0, 0);
      key0 = KEY_W; tick(1); key0 = 8'h00; tick(1);
      rst0_n = 1'b0; #1;
      chk("rstchk_x0", x0, 32); chk("rstchk_y0", y0, 416);
      chk("rstchk_f0", f0, 0);  chk("rstchk_rd0", rd0, 0);
      tick(2); rst0_n = 1'b1; tick(10);
      chk("rstchk_y0_after", y0, 416);

      // arrow-key player at the right edge
      exp1(0, 39, 0, 0, 0, 0);
      exp1(1, 0, 608, 32, 1, 2);
      exp1(2, 0, 608, 32, 1, 6);
      key1 = KEY_RIGHT; tick(1); key1 = 8'h00;
      chk("p1_turn_f1", f1, 1);
      tick(5);
      key1 = KEY_RIGHT; tick(1); key1 = 8'h00; tick(2);
      chk("p1_step_x1", x1, 608);
      tick(5);
      key1 = KEY_RIGHT; tick(1); key1 = 8'h00; tick(6);
      key1 = KEY_W; tick(3); key1 = 8'h00; tick(2);
      chk("p1_wasd_ignored_f1", f1, 1); chk("p1_final_x1", x1, 608);

      tick(2);
      chk("u0_queue_left", q0.size(), 0);
      chk("u1_queue_left", q1.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/tank_grid_mover.md
Name: tank_grid_mover

Overview:
Parametrised successor to the per-player tank position block. It moves one tank on a tile grid, one tile per accepted step. Before each move it checks collision by reading the shared tile map through a synchronous read port, rather than taking the whole map array as a port. It adds facing direction, a turn-before-move mode, a held-key repeat rate, a grid-edge check and respawn, and it feeds pixel coordinates and facing to the sprite and bullet logic.

Parameters:
PLAYER, 0, selects the keymap and start pose: 0 = WASD, 1 = arrow keys.
TILE_BITS, 5, log2 of the tile size in pixels (32 px tiles).
GRID_W, 20, number of tile columns.
GRID_H, 15, number of tile rows.
PIX_W, 10, width of the pixel coordinate outputs.
MOVE_PERIOD, 5, idle frames required between steps while a key is held.
TURN_FIRST, 1, when 1 a key for a new direction only turns the tank (no move).
START_COL / START_ROW, 1 / 13 when PLAYER=0, 18 / 1 when PLAYER=1, start tile.
ADDR_W, 9, map address width; ceil(log2(GRID_W*GRID_H)).

Ports:
frame_clk  in  1  only clock; one rising edge per video frame.
Reset  in  1  asynchronous, active-low reset.
keycode  in  8  current USB keycode; 0 means no key.
respawn  in  1  synchronous; returns the tank to the start pose.
map_rd_en  out  1  map read strobe, exactly one cycle wide.
map_addr  out  ADDR_W  tile index = row*GRID_W + col.
map_data  in  2  tile type, valid on the cycle after map_rd_en; 0 = passable.
TankX  out  PIX_W  pixel X = col << TILE_BITS.
TankY  out  PIX_W  pixel Y = row << TILE_BITS.
facing  out  2  dir_t: UP=0, RIGHT=1, DOWN=2, LEFT=3.
moved  out  1  one-cycle pulse when a step is committed.
blocked  out  1  one-cycle pulse when a step is rejected (wall or grid edge).

Behaviour:
- Reset low (asynchronous):
  - col/row = START_COL/START_ROW.
  - facing = UP for PLAYER 0, DOWN for PLAYER 1.
  - state = IDLE, cooldown = 0.
  - map_rd_en, moved, blocked = 0; map_addr = 0.
- All outputs are registered. TankX and TankY are derived from registered col/row (zero-extended, then shifted).
- FSM states: IDLE, REQ, CHECK.
- IDLE:
  - If cooldown != 0: decrement it and ignore keys.
  - Else, if the decoded key is valid for this PLAYER:
    - Turn-only case: if TURN_FIRST=1 and dir != facing, set facing = dir, load cooldown = MOVE_PERIOD, stay in IDLE. No map read.
    - Otherwise compute the target tile (col±1 or row±1). Set facing = dir.
    - If the target is off-grid (col 0 going LEFT, col GRID_W-1 going RIGHT, same rule for rows): pulse blocked, load cooldown = MOVE_PERIOD, stay in IDLE. No map read.
    - Else latch the target, register map_addr, go to REQ.
  - Invalid or zero keycodes are ignored.
- REQ: map_rd_en = 1 for this cycle only; go to CHECK.
- CHECK:
  - map_data == 0: commit col/row to the target and pulse moved.
  - map_data != 0: pulse blocked; col/row unchanged.
  - In both cases load cooldown = MOVE_PERIOD and go to IDLE.
- Latency: key accepted at edge E0 (IDLE→REQ). Read issued at E1. TankX/TankY show the new tile after E2.
- The target is latched at E0; keycode changes during REQ/CHECK have no effect.
- Held-key repeat: one step every MOVE_PERIOD+3 frames.
- Respawn, any state: restore the reset values of col, row, facing, state and cooldown, drop any read in flight (map_rd_en = 0 next cycle), no moved or blocked pulse. Reset has priority over respawn.
- Arithmetic: col and row are unsigned, widths of clog2(GRID_W) and clog2(GRID_H). The off-grid check runs before any ±1, so there is no wrap-around.
- map_addr uses an ADDR_W-wide multiply-add.

Decomposition:
- tank_pkg holds:
  - dir_t enum and the mover_state_t enum;
  - keycode constants: KEY_W 8'h1A, KEY_A 8'h04, KEY_S 8'h16, KEY_D 8'h07, KEY_UP 8'h52, KEY_DOWN 8'h51, KEY_LEFT 8'h50, KEY_RIGHT 8'h4F;
  - TILE_PASSABLE = 0.
- Sub-module tank_key_decode (combinational; PLAYER parameter; keycode in; dir and valid out). It is shared with the future bullet block.

Test Plan:
1. Reset low mid-CHECK with PLAYER=0 → immediately TankX=32, TankY=416, facing=UP, map_rd_en=0.
2. PLAYER=0, facing UP, map all 0, press D for 1 frame, TURN_FIRST=1 → facing=RIGHT, no map_rd_en, TankX still 32. Press D again after cooldown → map_addr=13*20+2=262, map_rd_en one cycle, TankX=64 after E2, moved pulse.
3. Tile 262 = 1, hold D → blocked pulse, TankX stays 32. Retries spaced exactly 8 frames apart (MOVE_PERIOD 5 + 3).
4. PLAYER=1 at col 18, row 1, facing RIGHT, press RIGHT (8'h4F) → col 19, TankX=608. Press again → blocked with no map read.
5. Hold W with an open column, 40 frames → exactly 5 moved pulses, TankY steps 416→384→…→256.
6. Assert respawn during REQ → next cycle map_rd_en=0, pose back to start, no moved or blocked pulse. The following key is honoured with no cooldown.
